aidc_lite_decomp_sched: RTL and testbench

- Command scheduler in front of the AIDC-Lite decompression engine.
- Queues up to DEPTH decompression descriptors (src addr, dst addr, length, tag) from a host-side push port.
- Launches them one at a time on the engine's config/start interface and waits for engine done, bounded by a per-command watchdog.
- Reports each result (tag, status) on a completion port and raises an interrupt level; this removes host status polling per command.

---
 rtl/aidc_lite_sched_pkg.sv | 31 +++
 rtl/aidc_lite_sched_fifo.sv | 59 +++++
 rtl/aidc_lite_decomp_sched.sv | 207 ++++++++++++++++++++
 tb/tb_aidc_lite_decomp_sched.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aidc_lite_sched_pkg.sv
// Shared types and default widths for the AIDC-Lite decompression command scheduler.
package aidc_lite_sched_pkg;

  localparam int DEF_DEPTH  = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LEN_W  = 32;
  localparam int DEF_TAG_W  = 4;
  localparam int DEF_WDOG_W = 20;
  localparam int CNT_W      = 16;

  // One decompression descriptor at the default widths.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] src;
    logic [DEF_ADDR_W-1:0] dst;
    logic [DEF_LEN_W-1:0]  len;
    logic [DEF_TAG_W-1:0]  tag;
  } desc_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY,
    REPORT
  } sched_state_t;

  // Packed width of a descriptor for arbitrary field widths.
  function automatic int desc_width(input int addr_w, input int len_w, input int tag_w);
    return 2 * addr_w + len_w + tag_w;
  endfunction

endpackage

// File: rtl/aidc_lite_sched_fifo.sv
// Synchronous first-word-fall-through FIFO holding pending descriptors.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module aidc_lite_sched_fifo
  import aidc_lite_sched_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // A push while full is accepted only when the same cycle frees the head slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign dout  = mem[rd_ptr_q[AW-1:0]];

  // Storage write.
  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  // Read and write pointer advance.
  // NOTE: clocked state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

endmodule

// File: rtl/aidc_lite_decomp_sched.sv
// Command scheduler in front of the AIDC-Lite decompression engine: queues host
// descriptors, launches them one at a time, guards each with a watchdog and posts
// a completion record plus interrupt level for every command.
module aidc_lite_decomp_sched
  import aidc_lite_sched_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int WDOG_W = DEF_WDOG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [ADDR_W-1:0] eng_src,
  output logic [ADDR_W-1:0] eng_dst,
  output logic [LEN_W-1:0]  eng_len,
  output logic              eng_start,
  input  logic              eng_done,
  output logic              eng_abort,
  output logic              cpl_valid,
  input  logic              cpl_ready,
  output logic [TAG_W-1:0]  cpl_tag,
  output logic              cpl_err,
  output logic              irq,
  output logic              busy,
  output logic [15:0]       done_cnt,
  output logic [15:0]       err_cnt
);

  localparam int DW = desc_width(ADDR_W, LEN_W, TAG_W);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [WDOG_W-1:0] WDOG_ONE = {{(WDOG_W-1){1'b0}}, 1'b1};
  localparam logic [WDOG_W-1:0] WDOG_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Descriptor layout at this instance's field widths.
  typedef struct packed {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
    logic [TAG_W-1:0]  tag;
  } cmd_desc_t;

  cmd_desc_t         push_desc;
  cmd_desc_t         head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              fifo_push;
  logic              fifo_pop;

  sched_state_t      state_q;
  sched_state_t      state_d;
  logic [WDOG_W-1:0] wdog_q;
  logic [WDOG_W-1:0] wdog_d;
  logic [ADDR_W-1:0] eng_src_q;
  logic [ADDR_W-1:0] eng_dst_q;
  logic [LEN_W-1:0]  eng_len_q;
  logic [TAG_W-1:0]  tag_q;
  logic              err_q;
  logic              err_d;
  logic              load_tag;
  logic              load_eng;
  logic              start_pulse;
  logic              abort_pulse;
  logic              cpl_fire;
  logic [CNT_W-1:0]  done_cnt_q;
  logic [CNT_W-1:0]  err_cnt_q;

  assign push_desc = '{src: cmd_src, dst: cmd_dst, len: cmd_len, tag: cmd_tag};

  // cmd_ready comes from the registered full flag, so a pop cannot reopen it in the same cycle.
  assign cmd_ready = ~fifo_full;
  assign fifo_push = cmd_valid & cmd_ready;

  aidc_lite_sched_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (push_desc),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state, watchdog and pulse decode for the launch/monitor/report sequence.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    err_d       = err_q;
    fifo_pop    = 1'b0;
    load_tag    = 1'b0;
    load_eng    = 1'b0;
    start_pulse = 1'b0;
    abort_pulse = 1'b0;
    cpl_fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          load_tag = 1'b1;
          if (head.len == '0) begin
            // Nothing to decompress: report the error without touching the engine.
            err_d   = 1'b1;
            state_d = REPORT;
          end else begin
            load_eng = 1'b1;
            state_d  = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        start_pulse = 1'b1;
        wdog_d      = '0;
        state_d     = BUSY;
      end
      BUSY: begin
        wdog_d = wdog_q + WDOG_ONE;
        if (eng_done) begin
          // Done wins over a watchdog expiry landing in the same cycle.
          err_d   = 1'b0;
          state_d = REPORT;
        end else if (wdog_d == WDOG_MAX) begin
          abort_pulse = 1'b1;
          err_d       = 1'b1;
          state_d     = REPORT;
        end
      end
      REPORT: begin
        if (cpl_ready) begin
          cpl_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scheduler state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Watchdog counter: cleared on launch, counts busy cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end

  // Command registers: tag/status per popped command, engine fields held until the next launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_src_q <= '0;
      eng_dst_q <= '0;
      eng_len_q <= '0;
      tag_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= err_d;
      if (load_tag) tag_q <= head.tag;
      if (load_eng) begin
        eng_src_q <= head.src;
        eng_dst_q <= head.dst;
        eng_len_q <= head.len;
      end
    end
  end

  // Completion statistics, counted on the completion handshake; both wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else if (cpl_fire) begin
      if (err_q) err_cnt_q  <= err_cnt_q + CNT_ONE;
      else       done_cnt_q <= done_cnt_q + CNT_ONE;
    end
  end

  assign eng_src   = eng_src_q;
  assign eng_dst   = eng_dst_q;
  assign eng_len   = eng_len_q;
  assign eng_start = start_pulse;
  assign eng_abort = abort_pulse;
  assign cpl_valid = (state_q == REPORT);
  assign cpl_tag   = tag_q;
  assign cpl_err   = err_q;
  assign irq       = cpl_valid;
  assign busy      = (state_q != IDLE) || (fifo_count != '0);
  assign done_cnt  = done_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_aidc_lite_decomp_sched.sv
// Bench for aidc_lite_decomp_sched: two instances (default watchdog and a 4-bit
// watchdog) share all inputs and are each compared every cycle against a
// queue-based model; directed sequences add literal expectations.
module tb_aidc_lite_decomp_sched;
  import aidc_lite_sched_pkg::*;

  localparam int DEPTH = 4;
  localparam int WD0   = 20;
  localparam int WD1   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [31:0] cmd_src, cmd_dst, cmd_len;
  logic [3:0]  cmd_tag;
  logic        eng_done;
  logic        cpl_ready;

  logic        cmd_ready_o [2];
  logic        eng_start_o [2];
  logic        eng_abort_o [2];
  logic        cpl_valid_o [2];
  logic        cpl_err_o   [2];
  logic        irq_o       [2];
  logic        busy_o      [2];
  logic [31:0] eng_src_o   [2];
  logic [31:0] eng_dst_o   [2];
  logic [31:0] eng_len_o   [2];
  logic [3:0]  cpl_tag_o   [2];
  logic [15:0] done_cnt_o  [2];
  logic [15:0] err_cnt_o   [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  aidc_lite_decomp_sched #(.DEPTH(DEPTH), .WDOG_W(WD0)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_o[0]),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_tag(cmd_tag),
    .eng_src(eng_src_o[0]), .eng_dst(eng_dst_o[0]), .eng_len(eng_len_o[0]),
    .eng_start(eng_start_o[0]), .eng_done(eng_done), .eng_abort(eng_abort_o[0]),
    .cpl_valid(cpl_valid_o[0]), .cpl_ready(cpl_ready), .cpl_tag(cpl_tag_o[0]),
    .cpl_err(cpl_err_o[0]), .irq(irq_o[0]), .busy(busy_o[0]),
    .done_cnt(done_cnt_o[0]), .err_cnt(err_cnt_o[0])
  );

  aidc_lite_decomp_sched #(.DEPTH(DEPTH), .WDOG_W(WD1)) dut_wd (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_o[1]),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_tag(cmd_tag),
    .eng_src(eng_src_o[1]), .eng_dst(eng_dst_o[1]), .eng_len(eng_len_o[1]),
    .eng_start(eng_start_o[1]), .eng_done(eng_done), .eng_abort(eng_abort_o[1]),
    .cpl_valid(cpl_valid_o[1]), .cpl_ready(cpl_ready), .cpl_tag(cpl_tag_o[1]),
    .cpl_err(cpl_err_o[1]), .irq(irq_o[1]), .busy(busy_o[1]),
    .done_cnt(done_cnt_o[1]), .err_cnt(err_cnt_o[1])
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s t=%0t actual=timeout required=event", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: pending queue, what the current command is doing
  // (0 nothing, 1 start cycle, 2 engine running, 3 result posted),
  // number of busy cycles spent so far, and the visible registers.
  desc_t       m_q     [2][$];
  int          m_stage [2];
  int          m_bc    [2];
  desc_t       m_eng   [2];
  logic [3:0]  m_tag   [2];
  logic        m_err   [2];
  logic [15:0] m_done  [2];
  logic [15:0] m_errc  [2];
  int          wmax    [2] = '{(1 << WD0) - 1, (1 << WD1) - 1};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_q[i].delete();
        m_stage[i] = 0;
        m_bc[i]    = 0;
        m_eng[i]   = '0;
        m_tag[i]   = '0;
        m_err[i]   = 1'b0;
        m_done[i]  = '0;
        m_errc[i]  = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit    acc;
        desc_t c;
        acc = cmd_valid && (m_q[i].size() < DEPTH);
        case (m_stage[i])
          0: if (m_q[i].size() > 0) begin
               c = m_q[i].pop_front();
               m_tag[i] = c.tag;
               if (c.len == 0) begin
                 m_err[i]   = 1'b1;
                 m_stage[i] = 3;
               end else begin
                 m_eng[i]   = c;
                 m_stage[i] = 1;
               end
             end
          1: begin
               m_stage[i] = 2;
               m_bc[i]    = 1;
             end
          2: if (eng_done) begin
               m_err[i]   = 1'b0;
               m_stage[i] = 3;
             end else if (m_bc[i] == wmax[i]) begin
               m_err[i]   = 1'b1;
               m_stage[i] = 3;
             end else begin
               m_bc[i]++;
             end
          3: if (cpl_ready) begin
               if (m_err[i]) m_errc[i]++;
               else          m_done[i]++;
               m_stage[i] = 0;
             end
          default: m_stage[i] = 0;
        endcase
        if (acc) m_q[i].push_back('{src: cmd_src, dst: cmd_dst, len: cmd_len, tag: cmd_tag});
      end
    end
  end

  // Compare both instances against the model in the middle of every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [138:0] a;
        logic [138:0] e;
        logic         ev;
        logic         eab;
        ev  = (m_stage[i] == 3);
        eab = (m_stage[i] == 2) && (m_bc[i] == wmax[i]) && !eng_done;
        a = {cmd_ready_o[i], eng_start_o[i], eng_abort_o[i], cpl_valid_o[i], irq_o[i], busy_o[i],
             eng_src_o[i], eng_dst_o[i], eng_len_o[i], done_cnt_o[i], err_cnt_o[i],
             ev ? {cpl_tag_o[i], cpl_err_o[i]} : 5'd0};
        e = {m_q[i].size() < DEPTH, m_stage[i] == 1, eab, ev, ev,
             (m_stage[i] != 0) || (m_q[i].size() > 0),
             m_eng[i].src, m_eng[i].dst, m_eng[i].len, m_done[i], m_errc[i],
             ev ? {m_tag[i], m_err[i]} : 5'd0};
        check($sformatf("cycle_dut%0d", i), {21'd0, a}, {21'd0, e});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l, input logic [3:0] t);
    cmd_valid = 1'b1;
    cmd_src   = s;
    cmd_dst   = d;
    cmd_len   = l;
    cmd_tag   = t;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start0(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (eng_start_o[0]) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) timeout_fail("wait_eng_start");
  endtask

  task automatic wait_cpl0(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (cpl_valid_o[0]) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) timeout_fail("wait_cpl_valid");
  endtask

  task automatic handshake();
    cpl_ready = 1'b1;
    step();
    cpl_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout t=%0t actual=running required=finished", $time);
    $fatal(1, "bench time limit");
  end

  initial begin
    bit       ok;
    int       exp_tags[$];
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_len   = '0;
    cmd_tag   = '0;
    eng_done  = 1'b0;
    cpl_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Reset values.
    check("rst_cmd_ready", cmd_ready_o[0], 1);
    check("rst_outputs", {eng_start_o[0], eng_abort_o[0], cpl_valid_o[0], irq_o[0], busy_o[0], cpl_tag_o[0], cpl_err_o[0]}, 0);
    check("rst_eng_fields", {eng_src_o[0], eng_dst_o[0], eng_len_o[0]}, 0);
    check("rst_counters", {done_cnt_o[0], err_cnt_o[0]}, 0);
    rst = 1'b0;
    step();

    // Single command; the 4-bit-watchdog instance times out on the same command.
    push(32'h0002_0000, 32'h0001_0000, 32'h0000_1000, 4'd3);
    step();
    check("single_start", eng_start_o[0], 1);
    check("single_fields", {eng_src_o[0], eng_dst_o[0], eng_len_o[0]}, {32'h0002_0000, 32'h0001_0000, 32'h0000_1000});
    check("wd_start", eng_start_o[1], 1);
    repeat (14) step();
    check("wd_abort_early", eng_abort_o[1], 0);
    step();
    check("wd_abort_pulse", eng_abort_o[1], 1);
    check("default_no_abort", eng_abort_o[0], 0);
    step();
    check("wd_abort_one_cycle", eng_abort_o[1], 0);
    check("wd_cpl", {cpl_valid_o[1], cpl_tag_o[1], cpl_err_o[1], irq_o[1]}, {1'b1, 4'd3, 1'b1, 1'b1});
    repeat (34) step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    check("single_cpl", {cpl_valid_o[0], cpl_tag_o[0], cpl_err_o[0], irq_o[0]}, {1'b1, 4'd3, 1'b0, 1'b1});
    handshake();
    check("single_done_cnt", {done_cnt_o[0], err_cnt_o[0]}, {16'd1, 16'd0});
    check("wd_err_cnt", {done_cnt_o[1], err_cnt_o[1]}, {16'd0, 16'd1});
    check("single_idle", {cpl_valid_o[0], busy_o[0]}, 0);

    // Zero-length command: no engine launch, error completion.
    push(32'h1234, 32'h5678, 32'h0, 4'd7);
    step();
    check("zero_cpl", {cpl_valid_o[0], cpl_tag_o[0], cpl_err_o[0], eng_start_o[0]}, {1'b1, 4'd7, 1'b1, 1'b0});
    handshake();
    check("zero_err_cnt", err_cnt_o[0], 1);

    // Queue full with the engine stalled, then completion backpressure.
    for (int i = 1; i <= 5; i++) begin
      check("qf_ready_open", cmd_ready_o[0], 1);
      push(32'h100 * i, 32'h200 * i, 32'h40 + i, 4'(i));
      exp_tags.push_back(i);
    end
    check("qf_ready_closed", cmd_ready_o[0], 0);
    repeat (5) step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    check("qf_first_cpl", {cpl_valid_o[0], cpl_tag_o[0]}, {1'b1, 4'd1});
    void'(exp_tags.pop_front());
    handshake();
    check("qf_ready_pop_cycle", cmd_ready_o[0], 0);
    step();
    check("qf_ready_reopen", cmd_ready_o[0], 1);
    check("qf_next_start", eng_start_o[0], 1);
    repeat (3) step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    void'(exp_tags.pop_front());
    for (int n = 0; n < 20; n++) begin
      check("bp_hold", {eng_start_o[0], cpl_valid_o[0], cpl_tag_o[0], cpl_err_o[0]}, {1'b0, 1'b1, 4'd2, 1'b0});
      step();
    end
    handshake();
    while (exp_tags.size() > 0) begin
      wait_start0(ok);
      if (!ok) break;
      step();
      step();
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
      wait_cpl0(ok);
      if (!ok) break;
      check("order_tag", cpl_tag_o[0], exp_tags.pop_front());
      handshake();
    end

    // Spurious done while idle is ignored.
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    step();
    check("spurious_idle", {cpl_valid_o[0], busy_o[0]}, 0);
    check("tally_default", {done_cnt_o[0], err_cnt_o[0]}, {16'd6, 16'd1});
    check("tally_wd", {done_cnt_o[1], err_cnt_o[1]}, {16'd5, 16'd2});

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_src   = $urandom;
      cmd_dst   = $urandom;
      cmd_len   = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      cmd_tag   = 4'($urandom);
      eng_done  = ($urandom_range(0, 7) == 0);
      cpl_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    cmd_valid = 1'b0;
    cpl_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      eng_done = ($urandom_range(0, 3) == 0);
      step();
    end
    eng_done  = 1'b0;
    cpl_ready = 1'b0;
    step();

    // Reset while the engine is busy.
    push(32'hA000, 32'hB000, 32'h80, 4'd9);
    repeat (4) step();
    check("rst_pre_busy", busy_o[0], 1);
    #1;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("midrst_outputs", {cmd_ready_o[i], eng_start_o[i], eng_abort_o[i], cpl_valid_o[i], irq_o[i], busy_o[i]}, 6'b100000);
      check("midrst_fields", {eng_src_o[i], eng_dst_o[i], eng_len_o[i], cpl_tag_o[i], cpl_err_o[i]}, 0);
      check("midrst_counters", {done_cnt_o[i], err_cnt_o[i]}, 0);
    end
    step();
    step();
    rst = 1'b0;
    step();
    push(32'hC000, 32'hD000, 32'h10, 4'd5);
    wait_start0(ok);
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    wait_cpl0(ok);
    check("post_rst_cpl", {cpl_tag_o[0], cpl_err_o[0]}, {4'd5, 1'b0});
    handshake();
    check("post_rst_done_cnt", done_cnt_o[0], 1);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
